parity_serializer: RTL

- Upstream feeder for the serial even/odd parity tracker.
- Accepts parallel words over a valid/ready handshake and shifts each word out MSB-first, one bit per clock, on a qualified serial stream (bit_out/bit_valid).
- Optionally appends a generated parity bit after the data bits.
- Inserts a programmable idle gap between frames.

---
 rtl/parity_serializer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/parity_serializer.sv
// Parallel-to-serial frame generator: shifts words out MSB-first on a qualified
// bit stream, optionally appends a parity bit, and spaces frames by an idle gap.
module parity_serializer #(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 1,
    parameter int ODD_PARITY = 0,
    parameter int GAP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              frame_start,
    output logic              frame_last,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] PRE_LAST_CNT = CNT_W'(DATA_W - 2);
    localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_PAR,
        S_GAP
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;
    logic [3:0]        gap_cnt;
    logic              par_bit;
    logic              final_bit;
    logic              accept;

    // State always describes the bit currently on bit_out, so the final-bit cycle is visible here.
    assign final_bit = (state == S_PAR) ||
                       ((state == S_SHIFT) && (cnt == LAST_CNT) && (PARITY_EN == 0));

    assign in_ready = !rst && ((state == S_IDLE) ||
                               ((state == S_GAP) && (gap_cnt == GAP_LAST)) ||
                               ((GAP_CYCLES == 0) && final_bit));

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            shreg       <= '0;
            cnt         <= '0;
            gap_cnt     <= '0;
            par_bit     <= 1'b0;
            bit_out     <= 1'b0;
            bit_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_last  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            frame_last  <= 1'b0;
            if (accept) begin
                // The MSB goes straight to bit_out; the shift register holds the remaining bits.
                state       <= S_SHIFT;
                cnt         <= '0;
                shreg       <= {in_data[DATA_W-2:0], 1'b0};
                par_bit     <= (^in_data) ^ 1'(ODD_PARITY);
                bit_out     <= in_data[DATA_W-1];
                bit_valid   <= 1'b1;
                frame_start <= 1'b1;
                busy        <= 1'b1;
            end else if (final_bit) begin
                bit_out   <= 1'b0;
                bit_valid <= 1'b0;
                gap_cnt   <= '0;
                if (GAP_CYCLES > 0) begin
                    state <= S_GAP;
                    busy  <= 1'b1;
                end else begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            end else begin
                case (state)
                    S_SHIFT: begin
                        if (cnt == LAST_CNT) begin
                            state      <= S_PAR;
                            bit_out    <= par_bit;
                            frame_last <= 1'b1;
                        end else begin
                            cnt        <= cnt + CNT_W'(1);
                            bit_out    <= shreg[DATA_W-1];
                            shreg      <= shreg << 1;
                            frame_last <= (cnt == PRE_LAST_CNT) && (PARITY_EN == 0);
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt == GAP_LAST) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            gap_cnt <= gap_cnt + 4'd1;
                        end
                    end
                    default: begin
                        state     <= S_IDLE;
                        bit_out   <= 1'b0;
                        bit_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
